// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the mini CPU control path: FSM states and opcodes.
// The opcode constants are also used by the ALU and RAM blocks.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_READ    = 3'd3,
    S_CALC    = 3'd4,
    S_DISPLAY = 3'd5,
    S_STORE   = 3'd6
  } state_t;

  localparam logic [2:0] OP_LOAD    = 3'd0;
  localparam logic [2:0] OP_ADD     = 3'd1;
  localparam logic [2:0] OP_ADDI    = 3'd2;
  localparam logic [2:0] OP_SUB     = 3'd3;
  localparam logic [2:0] OP_SUBI    = 3'd4;
  localparam logic [2:0] OP_MUL     = 3'd5;
  localparam logic [2:0] OP_CLEAR   = 3'd6;
  localparam logic [2:0] OP_DISPLAY = 3'd7;

  // States in which the controller waits on a peripheral handshake.
  function automatic logic is_wait_state(state_t s);
    return (s == S_READ) || (s == S_CALC) || (s == S_DISPLAY) || (s == S_STORE);
  endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Handshake bundle between the control FSM (master) and the RAM, ALU and LCD
// blocks (slave).
interface cpu_control_fsm_if;

  logic        ram_rd_req;
  logic        ram_rd_ack;
  logic        ram_wr_req;
  logic        ram_wr_ack;
  logic        ram_clr;
  logic [3:0]  ram_raddr1;
  logic [3:0]  ram_raddr2;
  logic [3:0]  ram_waddr;
  logic        alu_start;
  logic [2:0]  alu_opcode;
  logic [6:0]  alu_imm;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        lcd_update;
  logic        lcd_busy;

  modport master (
    output ram_rd_req, ram_wr_req, ram_clr, ram_raddr1, ram_raddr2, ram_waddr,
           alu_start, alu_opcode, alu_imm, lcd_update,
    input  ram_rd_ack, ram_wr_ack, alu_done, alu_result, lcd_busy
  );

  modport slave (
    input  ram_rd_req, ram_wr_req, ram_clr, ram_raddr1, ram_raddr2, ram_waddr,
           alu_start, alu_opcode, alu_imm, lcd_update,
    output ram_rd_ack, ram_wr_ack, alu_done, alu_result, lcd_busy
  );

endinterface

// File: rtl/cpu_control_fsm_button_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and a one-cycle
// pulse on the debounced release (active-low button going back to 1).
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic released
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          stable;
  logic [CW-1:0] cnt;

  // Idle level of the buttons is 1, so the synchronizer and stable level reset high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= 2'b11;
      stable   <= 1'b1;
      cnt      <= '0;
      released <= 1'b0;
    end else begin
      sync     <= {sync[0], btn};
      released <= 1'b0;
      if (sync[1] != stable) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable   <= sync[1];
          cnt      <= '0;
          released <= sync[1];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Mini CPU control unit: button events, instruction latch and the
// OFF/FETCH/DECODE/READ/CALC/DISPLAY/STORE sequence. Optional wait-state
// timeout is enabled by defining CPU_CTRL_TIMEOUT_EN.
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ligar,
  input  logic               enviar,
  input  logic [2:0]         opcode,
  input  logic [3:0]         addr1,
  input  logic [3:0]         addr2,
  input  logic [6:0]         addr3_imm,
  cpu_control_fsm_if.master  bus,
  output logic [15:0]        result,
  output logic               power_on,
  output logic               error
);

  state_t     state;
  logic       ligar_ev;
  logic       enviar_ev;
  logic       tmo_hit;
  logic [2:0] opcode_q;
  logic [3:0] addr1_q;
  logic [3:0] addr2_q;
  logic [6:0] imm_q;
  logic [3:0] raddr1;
  logic [3:0] raddr2;
  logic       rd_req;
  logic       wr_req;
  logic       clr;
  logic       alu_start;
  logic       lcd_update;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ligar (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (ligar),
    .released (ligar_ev)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enviar (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (enviar),
    .released (enviar_ev)
  );

`ifdef CPU_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  state_t        state_d;

  // Counts cycles spent in the current wait state; restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      state_d <= S_OFF;
    end else begin
      state_d <= state;
      if (state != state_d)
        tmo_cnt <= TW'(1);
      else if (is_wait_state(state))
        tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign tmo_hit = is_wait_state(state) && (state == state_d) &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  // Waits are unbounded; this comparison is always false.
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  // Single sequencing block; every output to the peripherals is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_OFF;
      opcode_q   <= '0;
      addr1_q    <= '0;
      addr2_q    <= '0;
      imm_q      <= '0;
      raddr1     <= '0;
      raddr2     <= '0;
      rd_req     <= 1'b0;
      wr_req     <= 1'b0;
      clr        <= 1'b0;
      alu_start  <= 1'b0;
      lcd_update <= 1'b0;
      result     <= '0;
      power_on   <= 1'b0;
      error      <= 1'b0;
    end else begin
      alu_start  <= 1'b0;
      lcd_update <= 1'b0;
      if (ligar_ev && (state != S_OFF)) begin
        state    <= S_OFF;
        rd_req   <= 1'b0;
        wr_req   <= 1'b0;
        clr      <= 1'b0;
        power_on <= 1'b0;
        error    <= 1'b0;
      end else if (tmo_hit) begin
        state  <= S_FETCH;
        rd_req <= 1'b0;
        wr_req <= 1'b0;
        clr    <= 1'b0;
        error  <= 1'b1;
      end else begin
        case (state)
          S_OFF: begin
            if (ligar_ev) begin
              state    <= S_FETCH;
              power_on <= 1'b1;
              error    <= 1'b0;
            end
          end
          S_FETCH: begin
            if (enviar_ev) begin
              opcode_q <= opcode;
              addr1_q  <= addr1;
              addr2_q  <= addr2;
              imm_q    <= addr3_imm;
              state    <= S_DECODE;
            end
          end
          S_DECODE: begin
            raddr1 <= (opcode_q == OP_DISPLAY) ? addr1_q : addr2_q;
            raddr2 <= imm_q[6:3];
            if (opcode_q == OP_LOAD) begin
              state     <= S_CALC;
              alu_start <= 1'b1;
            end else if (opcode_q == OP_CLEAR) begin
              state  <= S_STORE;
              wr_req <= 1'b1;
              clr    <= 1'b1;
            end else begin
              state  <= S_READ;
              rd_req <= 1'b1;
            end
          end
          S_READ: begin
            if (bus.ram_rd_ack) begin
              rd_req    <= 1'b0;
              state     <= S_CALC;
              alu_start <= 1'b1;
            end
          end
          // A done coincident with the start pulse belongs to no request.
          S_CALC: begin
            if (bus.alu_done && !alu_start) begin
              result <= bus.alu_result;
              state  <= S_DISPLAY;
            end
          end
          S_DISPLAY: begin
            if (!bus.lcd_busy) begin
              lcd_update <= 1'b1;
              if (opcode_q == OP_DISPLAY) begin
                state <= S_FETCH;
              end else begin
                state  <= S_STORE;
                wr_req <= 1'b1;
                clr    <= 1'b0;
              end
            end
          end
          S_STORE: begin
            if (bus.ram_wr_ack) begin
              wr_req <= 1'b0;
              clr    <= 1'b0;
              state  <= S_FETCH;
              if (opcode_q == OP_CLEAR) begin
                result     <= '0;
                lcd_update <= 1'b1;
              end
            end
          end
          default: state <= S_OFF;
        endcase
      end
    end
  end

  assign bus.ram_rd_req = rd_req;
  assign bus.ram_wr_req = wr_req;
  assign bus.ram_clr    = clr;
  assign bus.ram_raddr1 = raddr1;
  assign bus.ram_raddr2 = raddr2;
  assign bus.ram_waddr  = addr1_q;
  assign bus.alu_start  = alu_start;
  assign bus.alu_opcode = opcode_q;
  assign bus.alu_imm    = imm_q;
  assign bus.lcd_update = lcd_update;

endmodule

// File: doc/cpu_control_fsm.md
Name:
cpu_control_fsm

Overview:
Control unit for the mini CPU. It debounces the LIGAR/ENVIAR pushbuttons and latches one instruction per ENVIAR release. It then sequences the register RAM (read, write), the ALU (start/done) and the LCD (update/busy) through OFF→FETCH→DECODE→READ→CALC→DISPLAY→STORE, using req/ack handshakes so no stage relies on fixed latencies.

Parameters:
DEBOUNCE_CYCLES, 250000, stable cycles required before a button level is accepted (5 ms at 50 MHz).
TIMEOUT_CYCLES, 1024, wait-state limit; used only with CPU_CTRL_TIMEOUT_EN.

Ports:
clk  in  1  system clock; one clock domain.
rst_n  in  1  asynchronous, active-low reset.
ligar  in  1  power button, raw, active-low (0 = pressed).
enviar  in  1  send button, raw, active-low.
opcode  in  3  switch opcode (LOAD=0, ADD=1, ADDI=2, SUB=3, SUBI=4, MUL=5, CLEAR=6, DISPLAY=7).
addr1  in  4  destination register / DISPLAY source.
addr2  in  4  source register A.
addr3_imm  in  7  [6:3] = source register B; [6] = imm sign, [5:0] = imm magnitude.
ram_rd_req  out  1  RAM read request.
ram_rd_ack  in  1  RAM read data valid at the ALU.
ram_wr_req  out  1  RAM write request.
ram_wr_ack  in  1  RAM write committed.
ram_clr  out  1  qualifies ram_wr_req as clear-all.
ram_raddr1  out  4  latched read address 1.
ram_raddr2  out  4  latched read address 2.
ram_waddr  out  4  latched write address (= addr1).
alu_start  out  1  one-cycle ALU start pulse.
alu_opcode  out  3  latched opcode.
alu_imm  out  7  latched addr3_imm.
alu_done  in  1  ALU result valid.
alu_result  in  16  ALU output.
lcd_update  out  1  one-cycle LCD refresh pulse.
lcd_busy  in  1  LCD writing.
result  out  16  last displayed value.
power_on  out  1  high in every state except OFF.
error  out  1  sticky timeout flag.

Behaviour:
- Reset: state=OFF. All req/pulse outputs 0, result=0, power_on=0, error=0, latches=0.
- Buttons: 2-FF synchronizer, then debounce. An event is the debounced release (0→1), which produces a one-cycle pulse.
- OFF: ligar event→FETCH. enviar ignored.
- FETCH: enviar event→latch opcode/addr1/addr2/addr3_imm→DECODE. Latches are frozen until the next FETCH.
- DECODE (1 cycle):
  - LOAD→CALC.
  - CLEAR→STORE with ram_clr=1.
  - All other opcodes→READ.
  - Read addresses: raddr1=addr2, raddr2=addr3_imm[6:3]. DISPLAY uses raddr1=addr1.
- READ: ram_rd_req held until ram_rd_ack sampled high (an ack in the first cycle counts). The request drops the cycle after the ack; then go to CALC.
- CALC: alu_start pulses on entry, then wait for alu_done. On alu_done, result←alu_result and go to DISPLAY. A done in the same cycle as start is illegal and ignored.
- DISPLAY: wait until !lcd_busy, then pulse lcd_update. The DISPLAY opcode then goes to FETCH; all others go to STORE.
- STORE: ram_wr_req held until ram_wr_ack, then FETCH. ram_clr is 1 only for CLEAR. CLEAR also sets result=0 and pulses lcd_update before FETCH.
- ligar event in any non-OFF state: go to OFF next cycle.
  - All requests drop immediately; late acks and done are ignored.
  - The partial result is not written.
  - If ligar and enviar events occur in the same cycle, ligar wins.
- enviar events outside FETCH are discarded, not queued.
- Reset mid-handshake: requests deassert asynchronously.

Optional Feature:
CPU_CTRL_TIMEOUT_EN.
- Defined: a counter runs in READ/CALC/DISPLAY/STORE. When it reaches TIMEOUT_CYCLES, requests drop, error=1 and the state goes to FETCH. error is cleared by a ligar event or by reset.
- Undefined: waits are unbounded and error is tied 0.

Decomposition:
- Package cpu_ctrl_pkg holds the state encodings (OFF=0 … STORE=6) and the opcode constants, shared with the ALU and RAM.
- One sub-module, button_debounce (synchronizer + counter + release pulse), instantiated for ligar and enviar.

Test Plan:
(All tests use DEBOUNCE_CYCLES=4; RAM ack after 2 cycles; ALU done after 3 cycles.)
- Power-up: ligar press/release → power_on=1 and state FETCH. A 2-cycle glitch on ligar → no transition.
- ADD: addr1=3, addr2=1, addr3=2, enviar → ram_raddr1=1, raddr2=2, one alu_start; alu_result=0x0007 → result=7, one lcd_update, ram_wr_req with waddr=3, ack → FETCH.
- LOAD imm=-5 (addr3_imm=7'b1000101) → no ram_rd_req; alu_imm=0x45; write to addr1.
- DISPLAY addr1=9 → raddr1=9, no ram_wr_req; lcd_update is held while lcd_busy=1 and fires 1 cycle after it falls.
- ligar release during CALC → OFF next cycle; a later alu_done produces no write and result is unchanged. An enviar pressed in CALC is not executed afterwards.
- CLEAR → ram_wr_req with ram_clr=1, result=0. With CPU_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=8, a withheld ram_wr_ack → error=1 and FETCH after 8 cycles.
